// File: rtl/cache_ctrl_pkg.sv
// Shared types and constants for the cache request/response packet stream.
// Used by the responder RTL and by the bench helpers that build requests.
package cache_ctrl_pkg;

  localparam int CACHE_AW = 30;
  localparam int CACHE_DW = 32;

  typedef struct packed {
    logic                valid;
    logic [CACHE_AW-1:0] addr;
    logic                we;
    logic [CACHE_DW-1:0] wdat;
  } cache_req_t;

  typedef struct packed {
    logic                we;
    logic                err;
    logic [CACHE_DW-1:0] rdata;
  } cache_resp_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head read (show-ahead).
// DEPTH must be a power of two >= 2; the caller never pops empty or pushes full without a pop.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    count_d  = count_q + (PW+1)'(push) - (PW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // When full, push and pop share a slot: the head is read before the edge overwrites it.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

  assign pop_data = mem[rd_ptr_q];
  assign full     = (count_q == (PW+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign count    = count_q;

endmodule

// File: rtl/cache_pkt_responder.sv
// Target-side endpoint for the cache request stream: word memory, fixed-latency
// response pipeline and an in-order response queue with backpressure.
module cache_pkt_responder
  import cache_ctrl_pkg::*;
#(
  parameter int AW       = CACHE_AW,
  parameter int DW       = CACHE_DW,
  parameter int DEPTH    = 256,
  parameter int LATENCY  = 2,
  parameter int RQ_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic          req_we,
  input  logic [DW-1:0] req_wdat,
  output logic          resp_valid,
  input  logic          resp_ready,
  output logic          resp_we,
  output logic          resp_err,
  output logic [DW-1:0] resp_rdata
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(RQ_DEPTH) + 1;
  localparam int RW = DW + 2;

  logic [DW-1:0] mem [DEPTH];
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic          accept, err, pop, push;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [RW-1:0] push_data, head;
  logic [IW-1:0] idx;

  assign req_ready = (outstanding_q < CW'(RQ_DEPTH));
  assign accept    = req_valid && req_ready;
  assign err       = (req_addr >= AW'(DEPTH));
  assign idx       = req_addr[IW-1:0];
  assign pop       = resp_valid && resp_ready;

  // Outstanding covers pipeline plus queue, so it also bounds queue occupancy.
  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, pop})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) outstanding_q <= '0;
    else     outstanding_q <= outstanding_d;
  end

  always_ff @(posedge clk) begin
    if (accept && req_we && !err) mem[idx] <= req_wdat;
  end

  // The queue write is the last latency stage, so LATENCY-1 registers precede it.
  if (LATENCY == 1) begin : g_lat1
    assign push      = accept;
    assign push_data = {req_we, err, (req_we || err) ? {DW{1'b0}} : mem[idx]};
  end else begin : g_latn
    localparam int NREG = LATENCY - 1;

    logic          stage_vld  [NREG];
    logic [RW-1:0] stage_word [NREG];
    logic          vld0_q, vld0_d;
    logic [1:0]    meta0_q, meta0_d;
    logic [DW-1:0] mem_rd_q;

    always_comb begin
      vld0_d  = accept;
      meta0_d = {req_we, err};
    end

    always_ff @(posedge clk) begin
      mem_rd_q <= mem[idx];
      meta0_q  <= meta0_d;
      if (rst) vld0_q <= 1'b0;
      else     vld0_q <= vld0_d;
    end

    assign stage_vld[0]  = vld0_q;
    assign stage_word[0] = {meta0_q, (|meta0_q) ? {DW{1'b0}} : mem_rd_q};

    for (genvar gi = 1; gi < NREG; gi++) begin : g_stage
      logic          vld_q, vld_d;
      logic [RW-1:0] word_q, word_d;

      always_comb begin
        vld_d  = stage_vld[gi-1];
        word_d = stage_word[gi-1];
      end

      always_ff @(posedge clk) begin
        word_q <= word_d;
        if (rst) vld_q <= 1'b0;
        else     vld_q <= vld_d;
      end

      assign stage_vld[gi]  = vld_q;
      assign stage_word[gi] = word_q;
    end

    assign push      = stage_vld[NREG-1];
    assign push_data = stage_word[NREG-1];
  end

  sync_fifo #(
    .WIDTH (RW),
    .DEPTH (RQ_DEPTH)
  ) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  logic unused_fifo;
  assign unused_fifo = ^{fifo_full, fifo_count};

  assign resp_valid = !fifo_empty;
  assign {resp_we, resp_err, resp_rdata} = resp_valid ? head : {RW{1'b0}};

endmodule

// File: tb/tb_cache_pkt_responder.sv
// Randomized bench for cache_pkt_responder: a word-array model plus an expected
// response queue, checked at the negedge with per-response latency and hold checks.
module tb_cache_pkt_responder;
  import cache_ctrl_pkg::*;

  localparam int L   = 2;
  localparam int RQD = 4;
  localparam int DEP = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid, req_ready, req_we;
  logic [29:0] req_addr;
  logic [31:0] req_wdat;
  logic        resp_valid, resp_ready, resp_we, resp_err;
  logic [31:0] resp_rdata;

  always #5 clk = ~clk;

  cache_pkt_responder #(
    .AW (30), .DW (32), .DEPTH (DEP), .LATENCY (L), .RQ_DEPTH (RQD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_wdat   (req_wdat),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_we    (resp_we),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata)
  );

  typedef struct {
    logic        we;
    logic        err;
    logic [31:0] rdata;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] ref_mem [DEP];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          head_cyc = 0;
  int          n_resp = 0;
  bit          lat_on = 1'b0;
  bit          prev_stalled = 1'b0;
  logic [33:0] prev_head = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic cache_req_t mk_req(input bit v, input logic [29:0] a, input bit we,
                                        input logic [31:0] d);
    cache_req_t r;
    r.valid = v;
    r.addr  = a;
    r.we    = we;
    r.wdat  = d;
    return r;
  endfunction

  // One bus cycle: drive at negedge, observe 1ns later, update the model for the coming edge.
  task automatic cycle(input cache_req_t rq, input logic rr, output bit acc);
    logic [33:0] cur;
    @(negedge clk);
    req_valid  = rq.valid;
    req_addr   = rq.addr;
    req_we     = rq.we;
    req_wdat   = rq.wdat;
    resp_ready = rr;
    #1;
    cyc++;
    cur = {resp_we, resp_err, resp_rdata};
    if (resp_valid) begin
      if (!prev_stalled) head_cyc = cyc;
      else chk("hold", cur, prev_head);
    end else begin
      if (prev_stalled) chk("hold_valid", 0, 1);
      chk("idle_zero", cur, 0);
    end
    if (resp_valid && resp_ready) begin
      if (exp_q.size() == 0) begin
        chk("resp_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        n_resp++;
        $display("resp %0d we=%0b err=%0b rdata=%08h", n_resp, resp_we, resp_err, resp_rdata);
        chk("resp", cur, {e.we, e.err, e.rdata});
        if (lat_on) chk("latency", head_cyc - e.acc, L);
      end
    end
    prev_stalled = resp_valid && !resp_ready;
    prev_head    = cur;
    acc = req_valid && req_ready;
    if (acc) begin
      exp_t e;
      e.we    = rq.we;
      e.err   = (rq.addr >= DEP);
      e.rdata = '0;
      e.acc   = cyc;
      if (!e.err) begin
        if (rq.we) ref_mem[rq.addr[7:0]] = rq.wdat;
        else       e.rdata = ref_mem[rq.addr[7:0]];
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input cache_req_t rq, input logic rr);
    bit a;
    cycle(rq, rr, a);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && exp_q.size() > 0; i++) step(mk_req(0, 0, 0, 0), 1'b1);
    repeat (3) step(mk_req(0, 0, 0, 0), 1'b1);
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst        = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    prev_stalled = 1'b0;
  endtask

  initial begin
    bit          a;
    int          n;
    logic [29:0] addr;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_we     = 1'b0;
    req_wdat   = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(mk_req(0, 0, 0, 0), 1'b1);
      chk("rst_ready", req_ready, 1);
      chk("rst_valid", resp_valid, 0);
    end

    // Fill every word so later reads have known contents.
    lat_on = 1'b1;
    for (int i = 0; i < DEP; i++) begin
      cycle(mk_req(1, 30'(i), 1, $urandom), 1'b1, a);
      chk("fill_accept", a, 1);
    end
    drain();

    step(mk_req(1, 30'h10, 1, 32'hDEADBEEF), 1'b1);
    step(mk_req(1, 30'h10, 0, 32'h0), 1'b1);
    drain();

    step(mk_req(1, 30'h100, 1, 32'h12345678), 1'b1);
    step(mk_req(1, 30'h100, 0, 32'h0), 1'b1);
    step(mk_req(1, 30'h0, 0, 32'h0), 1'b1);
    drain();

    lat_on = 1'b0;
    n = 0;
    for (int i = 0; i < 6; i++) begin
      cycle(mk_req(1, 30'(i), 0, 0), 1'b0, a);
      n += int'(a);
    end
    chk("bp_accepted", n, RQD);
    chk("bp_ready_low", req_ready, 0);
    repeat (3) step(mk_req(0, 0, 0, 0), 1'b0);
    step(mk_req(0, 0, 0, 0), 1'b1);
    chk("bp_ready_at_pop", req_ready, 0);
    step(mk_req(0, 0, 0, 0), 1'b1);
    chk("bp_ready_after_pop", req_ready, 1);
    drain();

    lat_on = 1'b1;
    for (int i = 0; i < 64; i++) begin
      cycle(mk_req(1, 30'($urandom_range(0, DEP-1)), 1'($urandom_range(0, 1)), $urandom),
            1'b1, a);
      chk("stream_accept", a, 1);
    end
    drain();

    lat_on = 1'b0;
    for (int i = 0; i < 150; i++) begin
      addr = ($urandom_range(0, 7) == 0) ? 30'($urandom) : 30'($urandom_range(0, DEP-1));
      step(mk_req(1'($urandom_range(0, 1)), addr, 1'($urandom_range(0, 1)), $urandom),
           ($urandom_range(0, 3) != 0));
    end
    drain();

    step(mk_req(1, 30'h7, 1, 32'hA5A50707), 1'b0);
    step(mk_req(1, 30'h7, 0, 32'h0), 1'b0);
    step(mk_req(1, 30'h3, 0, 32'h0), 1'b0);
    do_reset();
    step(mk_req(0, 0, 0, 0), 1'b1);
    chk("mid_rst_ready", req_ready, 1);
    chk("mid_rst_valid", resp_valid, 0);
    repeat (10) step(mk_req(0, 0, 0, 0), 1'b1);
    n = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(mk_req(1, 30'h7, 0, 0), 1'b0, a);
      n += int'(a);
    end
    chk("post_rst_accepted", n, RQD);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_pkt_responder.md
Name: cache_pkt_responder

Overview:
- Target-side endpoint for the cache request packet stream (valid, 30-bit word address, we, 32-bit wdat).
- Sits behind the cache controller as an uncached/backing-store target and doubles as a synthesizable memory model for the cache_ctrl bench.
- Accepts requests under valid/ready, performs word read/write on an internal array, and returns one in-order response per request after fixed latency, buffered in a response queue with backpressure.

Parameters:
- AW, 30, request word-address width
- DW, 32, data width
- DEPTH, 256, memory words; power of two, >=2
- LATENCY, 2, cycles from request accept to earliest resp_valid; >=1
- RQ_DEPTH, 4, max outstanding requests (pipeline plus queue); power of two, >=LATENCY

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  responder can accept
- req_addr  in  AW  word address
- req_we  in  1  1=write, 0=read
- req_wdat  in  DW  write data
- resp_valid  out  1  response present
- resp_ready  in  1  consumer takes response
- resp_we  out  1  echo of request we (1 = write ack)
- resp_err  out  1  address out of range
- resp_rdata  out  DW  read data; 0 for writes and errors

Behaviour:
- Reset (synchronous, rst=1 at a clk edge): outstanding counter, pipeline valid bits, and queue pointers/count cleared. req_ready=1 and resp_valid=0 from the next cycle. resp_we, resp_err and resp_rdata read 0 while resp_valid=0.
- Memory contents are not reset. Writes already committed survive rst. In-flight and queued responses are discarded.
- Accept: occurs when req_valid && req_ready at an edge. req_ready = (outstanding < RQ_DEPTH), combinational from registered state only; it must not depend on req_valid or resp_ready.
- Outstanding counter (width clog2(RQ_DEPTH)+1):
  - +1 on accept.
  - -1 on resp handshake (resp_valid && resp_ready).
  - Both in the same cycle: unchanged.
  - Never exceeds RQ_DEPTH and never underflows.
- Range check: err = (req_addr >= DEPTH). Index the memory with req_addr[clog2(DEPTH)-1:0] only when err=0.
- Write (we=1, err=0): mem updated at the accept edge. Response: we=1, err=0, rdata=0.
- Read (we=0, err=0): data sampled at the accept edge. Ordering rules:
  - A read accepted in the cycle after a same-address write returns the new data.
  - One request per cycle, so there is no same-cycle read/write conflict.
- Error: write is dropped, mem is untouched, response has err=1 and rdata=0.
- Response path:
  - A LATENCY-stage shift pipeline of {we, err, rdata} with a per-stage valid.
  - Stage output is pushed into a RQ_DEPTH-entry FIFO.
  - resp_* driven from the FIFO head; resp_valid = FIFO non-empty.
- Latency: request accepted at edge t produces resp_valid high in the cycle after edge t+LATENCY-1 (LATENCY=1 means visible the cycle after accept), provided the queue is empty and the response goes straight to the head.
- Throughput: one request/cycle sustained while resp_ready=1.
- Queue full: guaranteed never to overflow, because outstanding bounds occupancy. A push to the FIFO is unconditional when stage output is valid. Push and pop in the same cycle are allowed at any occupancy, including full.
- Backpressure: resp_ready=0 holds the head stable (all resp_* unchanged) until the handshake. req_ready drops once outstanding reaches RQ_DEPTH and rises again the cycle after a pop.
- Ordering: strictly in order. Every accepted request yields exactly one response.
- Address wrap: none. Any address >= DEPTH errs; there is no aliasing.

Decomposition:
- cache_ctrl_pkg holds:
  - the packed request struct {valid, addr[AW-1:0], we, wdat[DW-1:0]}, shared with the bench helpers;
  - the packed resp struct {we, err, rdata[DW-1:0]};
  - constants CACHE_AW=30 and CACHE_DW=32.
- Sub-module sync_fifo: parameterized width/depth, push/pop/full/empty/count, synchronous active-high rst. It holds the response queue.
- The pipeline and memory stay in the top module.

Test Plan:
- Reset then idle: after rst, req_ready=1, resp_valid=0, resp_rdata=0, with no responses over 20 cycles.
- Write then read: write 0x00000010 <- 0xDEADBEEF, then read 0x10 on the next cycle with resp_ready=1. Expect a write ack (we=1, err=0, rdata=0) in the cycle after edge t+LATENCY-1, then a read response with rdata=0xDEADBEEF one cycle later.
- Out of range: write 0x100 <- 0x12345678, then read 0x100. Both responses have err=1 and rdata=0, and address 0x00 is still its prior value.
- Backpressure/full: resp_ready=0, issue 6 back-to-back reads. Exactly 4 are accepted and req_ready=0 thereafter. Raise resp_ready and expect the 4 responses in order, each held stable while stalled; req_ready returns to 1 one cycle after the first pop.
- Streaming: 64 random in-range reads/writes with valid every cycle and resp_ready=1. Expect zero bubbles after the initial latency and data matching a scoreboard model.
- Reset mid-operation: 3 outstanding requests queued, assert rst for 1 cycle. No stale responses appear, the counter returns to 0, and a write committed before rst reads back correctly afterwards.
